// File: rtl/dtbdm_pkg.sv
// dtbdm_pkg: shared types, widths and helpers for the dtbdm de-noising pipeline.
package dtbdm_pkg;
  localparam int MAX_W = 12;
  localparam int D_EXT = 1;
  localparam int F_EXT = 2;
  typedef enum logic [3:0] {
    DIR_D1, DIR_D2, DIR_D3, DIR_D4, DIR_D5, DIR_D6, DIR_D7, DIR_D8, DIR_FALLBACK
  } dir_e;
  function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
    return x > y ? x - y : y - x;
  endfunction
endpackage

// File: rtl/dtbdm_sort4.sv
// dtbdm_sort4: combinational 5-comparator ascending sorting network for four values.
module dtbdm_sort4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3
);
  logic [W-1:0] l0, h0, l1, h1, m_lo, m_hi;
  always_comb begin
    l0 = i0 < i1 ? i0 : i1;
    h0 = i0 < i1 ? i1 : i0;
    l1 = i2 < i3 ? i2 : i3;
    h1 = i2 < i3 ? i3 : i2;
    o0 = l0 < l1 ? l0 : l1;
    m_lo = l0 < l1 ? l1 : l0;
    m_hi = h0 < h1 ? h0 : h1;
    o3 = h0 < h1 ? h1 : h0;
    o1 = m_lo < m_hi ? m_lo : m_hi;
    o2 = m_lo < m_hi ? m_hi : m_lo;
  end
endmodule

// File: rtl/dtbdm_filter_pipe.sv
// dtbdm_filter_pipe: 3-stage decision-tree de-noising filter with valid/ready flow control.
// Define DTBDM_STATS_EN to add the saturating corrected-pixel counter (ovCorrCnt, iCntClr).
module dtbdm_filter_pipe
  import dtbdm_pkg::*;
#(
  parameter int PIX_W = 8
`ifdef DTBDM_STATS_EN
  , parameter int CNT_W = 24
`endif
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iDataValid,
  output logic             oReady,
  input  logic [PIX_W-1:0] iv8Minij,
  input  logic [PIX_W-1:0] iv8Maxij,
  input  logic [PIX_W-1:0] iv8Pixel_a,
  input  logic [PIX_W-1:0] iv8Pixel_b,
  input  logic [PIX_W-1:0] iv8Pixel_c,
  input  logic [PIX_W-1:0] iv8Pixel_d,
  input  logic [PIX_W-1:0] iv8Pixel_e,
  input  logic [PIX_W-1:0] iv8Pixel_f,
  input  logic [PIX_W-1:0] iv8Pixel_g,
  input  logic [PIX_W-1:0] iv8Pixel_h,
  input  logic [PIX_W-1:0] iv8Pixel_fij,
  input  logic             iReady,
  output logic [PIX_W-1:0] ov8PixelOut,
  output logic             oValid,
  output logic             oCorrected
`ifdef DTBDM_STATS_EN
  , output logic [CNT_W-1:0] ovCorrCnt,
  input  logic             iCntClr
`endif
);
  localparam int DW = PIX_W + D_EXT;
  localparam int FW = PIX_W + F_EXT;
  logic adv;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [8:0][PIX_W-1:0] px1_q, px1_d;
  logic [5:0] nz1_q, nz1_d;
  logic [3:0][PIX_W-1:0] bdeg2_q, bdeg2_d;
  logic [PIX_W-1:0] fcap2_q, fcap2_d, fij2_q, fij2_d, pix3_q, pix3_d;
  logic nf2_q, nf2_d, corr3_q, corr3_d;
  logic [PIX_W-1:0] a, b, c, d, e, f, g, h, fij;
  logic [DW-1:0] dk [8];
  logic [FW-1:0] fk [8];
  logic [FW-1:0] fb;
  logic [7:0] elig;
  dir_e dir;
  logic [DW-1:0] best;
  logic [PIX_W-1:0] s0, s1, s2, s3, est;
  logic unused_ok;
  function automatic logic [DW-1:0] ad(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
    return DW'(abs_diff(MAX_W'(x), MAX_W'(y)));
  endfunction
  function automatic logic [FW-1:0] zx(input logic [PIX_W-1:0] x);
    return FW'(x);
  endfunction
  function automatic logic noisy(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] mn, input logic [PIX_W-1:0] mx);
    return x >= mx || x <= mn;
  endfunction
  assign adv = iReady | ~v3_q;
  assign oReady = adv;
  assign {fij, h, g, f, e, d, c, b, a} = px1_q;
  assign ov8PixelOut = pix3_q;
  assign oValid = v3_q;
  assign oCorrected = corr3_q;
  assign unused_ok = ^{s0, s3};
  dtbdm_sort4 #(.W(PIX_W)) u_sort (
    .i0(bdeg2_q[0]), .i1(bdeg2_q[1]), .i2(bdeg2_q[2]), .i3(bdeg2_q[3]),
    .o0(s0), .o1(s1), .o2(s2), .o3(s3)
  );
  // nz bit order: d, e, f, g, h, fij
  always_comb begin
    v1_d = iDataValid;
    px1_d = {iv8Pixel_fij, iv8Pixel_h, iv8Pixel_g, iv8Pixel_f, iv8Pixel_e,
             iv8Pixel_d, iv8Pixel_c, iv8Pixel_b, iv8Pixel_a};
    nz1_d = {noisy(iv8Pixel_fij, iv8Minij, iv8Maxij), noisy(iv8Pixel_h, iv8Minij, iv8Maxij),
             noisy(iv8Pixel_g, iv8Minij, iv8Maxij), noisy(iv8Pixel_f, iv8Minij, iv8Maxij),
             noisy(iv8Pixel_e, iv8Minij, iv8Maxij), noisy(iv8Pixel_d, iv8Minij, iv8Maxij)};
    dk[0] = ad(d, h) + ad(a, e);
    dk[1] = ad(a, g) + ad(b, h);
    dk[2] = ad(b, g) << 1;
    dk[3] = ad(b, f) + ad(c, g);
    dk[4] = ad(c, d) + ad(e, f);
    dk[5] = ad(d, e) << 1;
    dk[6] = ad(a, h) << 1;
    dk[7] = ad(c, f) << 1;
    fk[0] = (zx(d) + zx(h) + zx(a) + zx(e)) >> 2;
    fk[1] = (zx(a) + zx(g) + zx(b) + zx(h)) >> 2;
    fk[2] = (zx(b) + zx(g)) >> 1;
    fk[3] = (zx(b) + zx(f) + zx(c) + zx(g)) >> 2;
    fk[4] = (zx(c) + zx(d) + zx(e) + zx(f)) >> 2;
    fk[5] = (zx(d) + zx(e)) >> 1;
    fk[6] = (zx(a) + zx(h)) >> 1;
    fk[7] = (zx(c) + zx(f)) >> 1;
    fb = (zx(a) + (zx(b) << 1) + zx(c)) >> 2;
    elig = {~nz1_q[2], ~nz1_q[4], ~(nz1_q[0] | nz1_q[1]), ~(nz1_q[0] | nz1_q[1] | nz1_q[2]),
            ~(nz1_q[2] | nz1_q[3]), ~nz1_q[3], ~(nz1_q[3] | nz1_q[4]), ~(nz1_q[0] | nz1_q[1] | nz1_q[4])};
    dir = DIR_FALLBACK;
    best = '1;
    // strict compare keeps the lowest index on ties
    for (int k = 0; k < 8; k++)
      if (elig[k] && (dir == DIR_FALLBACK || dk[k] < best)) begin
        dir = dir_e'(k);
        best = dk[k];
      end
    v2_d = v1_q;
    bdeg2_d = {g, e, d, b};
    fcap2_d = PIX_W'(dir == DIR_FALLBACK ? fb : fk[dir[2:0]]);
    fij2_d = fij;
    nf2_d = nz1_q[5];
    v3_d = v2_q;
    est = s1 > fcap2_q ? s1 : s2 < fcap2_q ? s2 : fcap2_q;
    pix3_d = nf2_q ? est : fij2_q;
    corr3_d = nf2_q;
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      px1_q <= '0;
      nz1_q <= '0;
      bdeg2_q <= '0;
      fcap2_q <= '0;
      fij2_q <= '0;
      nf2_q <= 1'b0;
      pix3_q <= '0;
      corr3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      px1_q <= px1_d;
      nz1_q <= nz1_d;
      bdeg2_q <= bdeg2_d;
      fcap2_q <= fcap2_d;
      fij2_q <= fij2_d;
      nf2_q <= nf2_d;
      pix3_q <= pix3_d;
      corr3_q <= corr3_d;
    end
`ifdef DTBDM_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = iCntClr ? '0 : (v3_q & iReady & corr3_q & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign ovCorrCnt = cnt_q;
`endif
endmodule

// File: tb/tb_dtbdm_filter_pipe.sv
// tb_dtbdm_filter_pipe: directed + randomized checks of dtbdm_filter_pipe against a window-level reference model.
module tb_dtbdm_filter_pipe;
  typedef int win_t [11];
  typedef struct {int pix; int corr;} exp_t;
  logic iClk, iRst, iDataValid, oReady, iReady, oValid, oCorrected;
  logic [7:0] iv8Minij, iv8Maxij, iv8Pixel_a, iv8Pixel_b, iv8Pixel_c, iv8Pixel_d;
  logic [7:0] iv8Pixel_e, iv8Pixel_f, iv8Pixel_g, iv8Pixel_h, iv8Pixel_fij, ov8PixelOut;
`ifdef DTBDM_STATS_EN
  localparam int CMAX = (1 << 24) - 1;
  logic [23:0] ovCorrCnt;
  logic iCntClr;
  int exp_cnt;
`endif
  int n_chk, n_err;
  exp_t q[$];
  int seen[$];
  int last_corr, hold_pix, hold_corr;
  bit stall_prev, acc_last, vld_seen;
  int dt [8][4] = '{'{3,7,0,4}, '{0,6,1,7}, '{1,6,1,6}, '{1,5,2,6},
                    '{2,3,4,5}, '{3,4,3,4}, '{0,7,0,7}, '{2,5,2,5}};

  dtbdm_filter_pipe dut (
    .iClk(iClk), .iRst(iRst), .iDataValid(iDataValid), .oReady(oReady),
    .iv8Minij(iv8Minij), .iv8Maxij(iv8Maxij),
    .iv8Pixel_a(iv8Pixel_a), .iv8Pixel_b(iv8Pixel_b), .iv8Pixel_c(iv8Pixel_c),
    .iv8Pixel_d(iv8Pixel_d), .iv8Pixel_e(iv8Pixel_e), .iv8Pixel_f(iv8Pixel_f),
    .iv8Pixel_g(iv8Pixel_g), .iv8Pixel_h(iv8Pixel_h), .iv8Pixel_fij(iv8Pixel_fij),
    .iReady(iReady), .ov8PixelOut(ov8PixelOut), .oValid(oValid), .oCorrected(oCorrected)
`ifdef DTBDM_STATS_EN
    , .ovCorrCnt(ovCorrCnt), .iCntClr(iCntClr)
`endif
  );

  initial iClk = 0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Window order: a b c d e f g h fij min max
  function automatic void model(input win_t w, output int pix, output int corr);
    int nz[9];
    int s[4];
    int best, bestd, dd, fcap, t, est;
    bit ok;
    for (int i = 0; i < 9; i++) nz[i] = (w[i] >= w[10] || w[i] <= w[9]) ? 1 : 0;
    best = -1;
    bestd = 0;
    for (int k = 0; k < 8; k++) begin
      ok = 1;
      for (int j = 0; j < 4; j++) if (dt[k][j] >= 3 && dt[k][j] <= 7 && nz[dt[k][j]] == 1) ok = 0;
      dd = (w[dt[k][0]] > w[dt[k][1]] ? w[dt[k][0]] - w[dt[k][1]] : w[dt[k][1]] - w[dt[k][0]])
         + (w[dt[k][2]] > w[dt[k][3]] ? w[dt[k][2]] - w[dt[k][3]] : w[dt[k][3]] - w[dt[k][2]]);
      if (ok && (best < 0 || dd < bestd)) begin
        best = k;
        bestd = dd;
      end
    end
    if (best < 0) fcap = (w[0] + 2 * w[1] + w[2]) / 4;
    else fcap = (w[dt[best][0]] + w[dt[best][1]] + w[dt[best][2]] + w[dt[best][3]]) / 4;
    s = '{w[1], w[3], w[4], w[6]};
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    est = s[1] > fcap ? s[1] : (s[2] < fcap ? s[2] : fcap);
    pix = nz[8] ? est : w[8];
    corr = nz[8];
  endfunction

  task automatic set_win(input win_t w);
    iv8Pixel_a = 8'(w[0]); iv8Pixel_b = 8'(w[1]); iv8Pixel_c = 8'(w[2]);
    iv8Pixel_d = 8'(w[3]); iv8Pixel_e = 8'(w[4]); iv8Pixel_f = 8'(w[5]);
    iv8Pixel_g = 8'(w[6]); iv8Pixel_h = 8'(w[7]); iv8Pixel_fij = 8'(w[8]);
    iv8Minij = 8'(w[9]); iv8Maxij = 8'(w[10]);
  endtask

  function automatic void get_win(output win_t w);
    w = '{int'(iv8Pixel_a), int'(iv8Pixel_b), int'(iv8Pixel_c), int'(iv8Pixel_d),
          int'(iv8Pixel_e), int'(iv8Pixel_f), int'(iv8Pixel_g), int'(iv8Pixel_h),
          int'(iv8Pixel_fij), int'(iv8Minij), int'(iv8Maxij)};
  endfunction

  task automatic rand_win(output win_t w);
    int r;
    w[9] = $urandom_range(0, 60);
    w[10] = $urandom_range(190, 255);
    if ($urandom_range(0, 3) == 0) begin w[9] = 0; w[10] = 255; end
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(0, 9);
      w[i] = r == 0 ? $urandom_range(0, w[9]) : r == 1 ? $urandom_range(w[10], 255) : $urandom_range(0, 255);
    end
  endtask

  // Observes the DUT at the falling edge, between active edges.
  task automatic mon;
    win_t w;
    exp_t x;
    int p, cr;
    if (iRst) begin
      q.delete();
      stall_prev = 0;
      acc_last = 0;
      vld_seen = 0;
`ifdef DTBDM_STATS_EN
      exp_cnt = 0;
`endif
      return;
    end
    vld_seen = oValid;
    if (stall_prev) begin
      chk("hold_vld", oValid, 1);
      chk("hold_pix", ov8PixelOut, hold_pix);
      chk("hold_corr", oCorrected, hold_corr);
    end
    if (oValid && iReady) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        x = q.pop_front();
        chk("pix", ov8PixelOut, x.pix);
        chk("corr", oCorrected, x.corr);
      end
      seen.push_back(ov8PixelOut);
      last_corr = oCorrected;
    end
`ifdef DTBDM_STATS_EN
    exp_cnt = iCntClr ? 0 : (oValid && iReady && oCorrected) ? (exp_cnt == CMAX ? CMAX : exp_cnt + 1) : exp_cnt;
`endif
    acc_last = iDataValid && oReady;
    if (acc_last) begin
      get_win(w);
      model(w, p, cr);
      x.pix = p;
      x.corr = cr;
      q.push_back(x);
    end
    stall_prev = oValid && !iReady;
    hold_pix = ov8PixelOut;
    hold_corr = oCorrected;
  endtask

  task automatic step;
    @(negedge iClk);
    mon();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input win_t w);
    int t;
    set_win(w);
    iDataValid = 1;
    t = 0;
    do begin step(); t++; end while (!acc_last && t < 200);
    if (!acc_last) chk("send_timeout", 0, 1);
    iDataValid = 0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin step(); t++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    win_t w;
    int c, base, sent;
    bit pending;
    n_chk = 0; n_err = 0;
    iRst = 1; iDataValid = 0; iReady = 1;
    set_win('{0,0,0,0,0,0,0,0,0,0,0});
`ifdef DTBDM_STATS_EN
    iCntClr = 0;
`endif
    #3;
    chk("rst_vld", oValid, 0);
    chk("rst_pix", ov8PixelOut, 0);
    chk("rst_corr", oCorrected, 0);
    chk("rst_ordy", oReady, 1);
`ifdef DTBDM_STATS_EN
    chk("rst_cnt", ovCorrCnt, 0);
`endif
    @(posedge iClk); #1;
    iRst = 0;
    step();
    // noisy centre in a flat window, with latency
    send('{100,100,100,100,100,100,100,100,255,0,255});
    c = 0;
    do begin step(); c++; end while (!vld_seen && c < 20);
    chk("latency", c, 3);
    drain();
    chk("t1_pix", seen[$], 100);
    chk("t1_corr", last_corr, 1);
    send('{100,100,100,100,100,100,100,100,120,0,255});
    drain();
    chk("t2_pix", seen[$], 120);
    chk("t2_corr", last_corr, 0);
    send('{10,20,30,255,255,255,255,255,0,0,255});
    drain();
    chk("t3_fallback_pix", seen[$], 255);
    chk("t3_corr", last_corr, 1);
    send('{40,40,40,40,40,40,40,40,0,0,255});
    drain();
    chk("t4_tie_pix", seen[$], 40);
    // backpressure: three beats then a 5-cycle stall
    base = seen.size();
    send('{100,100,100,100,100,100,100,100,11,0,255});
    send('{100,100,100,100,100,100,100,100,22,0,255});
    send('{100,100,100,100,100,100,100,100,33,0,255});
    iReady = 0;
    repeat (5) begin step(); chk("bp_ordy", oReady, 0); end
    iReady = 1;
    drain();
    chk("bp_count", seen.size() - base, 3);
    for (int i = 0; i < 3; i++) chk("bp_order", seen[base + i], 11 * (i + 1));
    // reset with two beats in flight
    send('{100,100,100,100,100,100,100,100,255,0,255});
    send('{100,100,100,100,100,100,100,100,255,0,255});
    step();
    chk("pre_rst_vld", oValid, 1);
    #2 iRst = 1;
    #1;
    chk("rst_async_vld", oValid, 0);
    chk("rst_async_pix", ov8PixelOut, 0);
    step();
    step();
    iRst = 0;
    repeat (4) begin step(); chk("post_rst_vld", oValid, 0); end
`ifdef DTBDM_STATS_EN
    iCntClr = 1;
    step();
    iCntClr = 0;
    chk("cnt_clr0", ovCorrCnt, 0);
    repeat (4) send('{100,100,100,100,100,100,100,100,255,0,255});
    drain();
    chk("cnt4", ovCorrCnt, 4);
    iCntClr = 1;
    step();
    iCntClr = 0;
    chk("cnt_clr1", ovCorrCnt, 0);
`endif
    // randomized traffic with random backpressure and bubbles
    sent = 0;
    pending = 0;
    for (int n = 0; n < 3000 && (sent < 300 || pending); n++) begin
      if (!pending && sent < 300 && $urandom_range(0, 4) != 0) begin
        rand_win(w);
        set_win(w);
        iDataValid = 1;
        pending = 1;
        sent++;
      end
      iReady = $urandom_range(0, 3) != 0;
`ifdef DTBDM_STATS_EN
      iCntClr = $urandom_range(0, 19) == 0;
`endif
      step();
      if (acc_last) begin pending = 0; iDataValid = 0; end
    end
    if (pending) chk("rand_send_timeout", 0, 1);
    iDataValid = 0;
    iReady = 1;
`ifdef DTBDM_STATS_EN
    iCntClr = 0;
`endif
    drain();
`ifdef DTBDM_STATS_EN
    chk("cnt_rand", ovCorrCnt, exp_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
